// File: rtl/pmu_counter_bank.sv
// Bank of free-running 64-bit event counters with a control register and a
// sticky overflow register, accessed through independent four-phase read/write ports.
module pmu_counter_bank #(
    parameter int N_COUNTERS    = 23,
    parameter int COUNTER_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_COUNTERS-1:0]    events,
    input  logic                     counter_read_enable,
    input  logic [7:0]               counter_read_address,
    output logic                     counter_read_valid,
    output logic [COUNTER_WIDTH-1:0] counter_read_data,
    input  logic                     counter_write_enable,
    input  logic [7:0]               counter_write_address,
    input  logic [COUNTER_WIDTH-1:0] counter_write_data,
    output logic                     counter_write_valid
);

    localparam logic [7:0] OVF_IDX  = 8'(N_COUNTERS + 1);
    localparam int         OVF_BITS = (N_COUNTERS < COUNTER_WIDTH) ? N_COUNTERS : COUNTER_WIDTH;

    typedef enum logic {R_IDLE, R_ACK} rd_state_t;
    typedef enum logic {W_IDLE, W_ACK} wr_state_t;

    rd_state_t                  rd_state_q;
    wr_state_t                  wr_state_q;
    logic                       rd_valid_q;
    logic [COUNTER_WIDTH-1:0]   rd_data_q;
    logic                       wr_valid_q;
    logic                       ctrl_en_q;
    logic [N_COUNTERS-1:0]      ovf_q;
    logic [COUNTER_WIDTH-1:0]   cnt_q [N_COUNTERS];

    logic                       wr_fire;
    logic                       wr_ctrl;
    logic                       wr_ovf;
    logic                       clear_all;
    logic [N_COUNTERS-1:0]      ovf_set;
    logic [N_COUNTERS-1:0]      ovf_clr;
    logic [COUNTER_WIDTH-1:0]   ovf_rd;
    logic [COUNTER_WIDTH-1:0]   rd_val;

    // A register write takes effect only on the cycle the write FSM leaves W_IDLE.
    assign wr_fire   = (wr_state_q == W_IDLE) && counter_write_enable;
    assign wr_ctrl   = wr_fire && (counter_write_address == 8'd0);
    assign wr_ovf    = wr_fire && (counter_write_address == OVF_IDX);
    assign clear_all = wr_ctrl && counter_write_data[1];

    always_comb begin
        ovf_rd = '0;
        ovf_rd[OVF_BITS-1:0] = ovf_q[OVF_BITS-1:0];
    end

    // Read mux sees registered state only, so it returns pre-write, pre-increment values.
    always_comb begin
        rd_val = '0;
        if (counter_read_address == 8'd0) begin
            rd_val[0] = ctrl_en_q;
        end else if (counter_read_address == OVF_IDX) begin
            rd_val = ovf_rd;
        end else begin
            for (int i = 0; i < N_COUNTERS; i++) begin
                if (counter_read_address == 8'(i + 1)) begin
                    rd_val = cnt_q[i];
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_COUNTERS; gi++) begin : g_cnt
            logic                     hit;
            logic                     inc;
            logic [COUNTER_WIDTH-1:0] cnt_d;

            assign hit = wr_fire && (counter_write_address == 8'(gi + 1));
            // A same-cycle write or clear swallows the event, including its overflow.
            assign inc = ctrl_en_q && events[gi] && !hit && !clear_all;
            assign ovf_set[gi] = inc && (&cnt_q[gi]);

            if (gi < COUNTER_WIDTH) begin : g_clr
                assign ovf_clr[gi] = wr_ovf && counter_write_data[gi];
            end else begin : g_noclr
                assign ovf_clr[gi] = 1'b0;
            end

            always_comb begin
                cnt_d = cnt_q[gi];
                if (clear_all) begin
                    cnt_d = '0;
                end else if (hit) begin
                    cnt_d = counter_write_data;
                end else if (inc) begin
                    cnt_d = cnt_q[gi] + COUNTER_WIDTH'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q[gi] <= '0;
                end else begin
                    cnt_q[gi] <= cnt_d;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_en_q <= 1'b0;
            ovf_q     <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en_q <= counter_write_data[0];
            end
            ovf_q <= (ovf_q & ~ovf_clr) | ovf_set;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            case (rd_state_q)
                R_IDLE: if (counter_read_enable) begin
                    rd_data_q  <= rd_val;
                    rd_valid_q <= 1'b1;
                    rd_state_q <= R_ACK;
                end
                R_ACK: if (!counter_read_enable) begin
                    rd_valid_q <= 1'b0;
                    rd_state_q <= R_IDLE;
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            wr_valid_q <= 1'b0;
        end else begin
            case (wr_state_q)
                W_IDLE: if (counter_write_enable) begin
                    wr_valid_q <= 1'b1;
                    wr_state_q <= W_ACK;
                end
                W_ACK: if (!counter_write_enable) begin
                    wr_valid_q <= 1'b0;
                    wr_state_q <= W_IDLE;
                end
                default: wr_state_q <= W_IDLE;
            endcase
        end
    end

    assign counter_read_valid  = rd_valid_q;
    assign counter_read_data   = rd_data_q;
    assign counter_write_valid = wr_valid_q;

endmodule

// File: tb/tb_pmu_counter_bank.sv
// Directed bench for pmu_counter_bank: read expectations are queued by the
// stimulus tasks and checked by an independent monitor when read valid rises.
module tb_pmu_counter_bank;

    localparam int         N   = 23;
    localparam logic [7:0] OVF = 8'd24;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  events;
    logic          counter_read_enable;
    logic [7:0]    counter_read_address;
    logic          counter_read_valid;
    logic [63:0]   counter_read_data;
    logic          counter_write_enable;
    logic [7:0]    counter_write_address;
    logic [63:0]   counter_write_data;
    logic          counter_write_valid;

    always #5 clk = ~clk;

    pmu_counter_bank #(.N_COUNTERS(N), .COUNTER_WIDTH(64)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .events                (events),
        .counter_read_enable   (counter_read_enable),
        .counter_read_address  (counter_read_address),
        .counter_read_valid    (counter_read_valid),
        .counter_read_data     (counter_read_data),
        .counter_write_enable  (counter_write_enable),
        .counter_write_address (counter_write_address),
        .counter_write_data    (counter_write_data),
        .counter_write_valid   (counter_write_valid)
    );

    int          checks = 0;
    int          failures = 0;
    int          wr_acks = 0;
    int          exp_wr_acks = 0;
    logic [63:0] rd_exp_q [$];
    logic [63:0] mon_exp;
    logic [63:0] mon_held;
    logic        prev_rv = 1'b0;
    logic        prev_wv = 1'b0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected read value per valid rising edge, checks data stays held.
    always @(negedge clk) begin
        if (counter_read_valid && !prev_rv) begin
            if (rd_exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected: got %h expected no transaction", counter_read_data);
            end else begin
                mon_exp = rd_exp_q.pop_front();
                check64("rd_data", counter_read_data, mon_exp);
            end
            mon_held = counter_read_data;
        end else if (counter_read_valid && prev_rv) begin
            check64("rd_hold", counter_read_data, mon_held);
        end
        if (counter_write_valid && !prev_wv) wr_acks++;
        prev_rv = counter_read_valid;
        prev_wv = counter_write_valid;
    end

    task automatic do_read(input logic [7:0] a, input logic [63:0] exp, input int hold);
        int n;
        rd_exp_q.push_back(exp);
        @(posedge clk); #1;
        counter_read_address = a;
        counter_read_enable  = 1'b1;
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!counter_read_valid && n < 20);
        check64("rd_latency", 64'(n), 64'd1);
        repeat (hold) @(negedge clk);
        @(posedge clk); #1;
        counter_read_enable = 1'b0;
        @(negedge clk);
        check64("rd_valid_held", 64'(counter_read_valid), 64'd1);
        @(negedge clk);
        check64("rd_valid_drop", 64'(counter_read_valid), 64'd0);
        $display("read  addr=%0d expect=%h", a, exp);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [63:0] d, input int hold);
        int n;
        exp_wr_acks++;
        @(posedge clk); #1;
        counter_write_address = a;
        counter_write_data    = d;
        counter_write_enable  = 1'b1;
        @(posedge clk);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!counter_write_valid && n < 20);
        check64("wr_latency", 64'(n), 64'd1);
        repeat (hold) @(negedge clk);
        @(posedge clk); #1;
        counter_write_enable = 1'b0;
        @(negedge clk);
        check64("wr_valid_held", 64'(counter_write_valid), 64'd1);
        @(negedge clk);
        check64("wr_valid_drop", 64'(counter_write_valid), 64'd0);
        $display("write addr=%0d data=%h", a, d);
    endtask

    task automatic pulse(input logic [N-1:0] m, input int c);
        @(posedge clk); #1;
        events = m;
        repeat (c) @(posedge clk);
        #1;
        events = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        events = '0;
        counter_read_enable = 1'b0;
        counter_read_address = '0;
        counter_write_enable = 1'b0;
        counter_write_address = '0;
        counter_write_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check64("reset_rd_valid", 64'(counter_read_valid), 64'd0);
        check64("reset_wr_valid", 64'(counter_write_valid), 64'd0);
        check64("reset_rd_data", counter_read_data, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_read(8'd0, 64'd0, 0);
        do_read(8'd4, 64'd0, 0);
        do_read(OVF, 64'd0, 0);

        // Basic counting
        do_write(8'd0, 64'd1, 0);
        pulse(23'h8, 5);
        do_read(8'd4, 64'd5, 3);
        do_read(8'd1, 64'd0, 0);

        // Wrap and sticky overflow
        do_write(8'd1, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        pulse(23'h1, 2);
        do_read(8'd1, 64'd0, 0);
        do_read(OVF, 64'h1, 0);

        // Write beats a same-cycle event; a long-held write commits once
        fork
            do_write(8'd2, 64'd100, 0);
            pulse(23'h2, 1);
        join
        do_read(8'd2, 64'd100, 0);
        fork
            do_write(8'd2, 64'd50, 10);
            pulse(23'h2, 5);
        join
        do_read(8'd2, 64'd54, 0);

        // Clear-all drops same-cycle events, leaves OVF, keeps enable bit
        fork
            do_write(8'd0, 64'h3, 0);
            pulse(23'h8, 1);
        join
        do_read(8'd4, 64'd0, 0);
        do_read(8'd2, 64'd0, 0);
        do_read(8'd0, 64'h1, 0);
        do_read(OVF, 64'h1, 0);
        pulse(23'h8, 2);
        do_read(8'd4, 64'd2, 0);

        // OVF is write-one-to-clear
        do_write(OVF, 64'h0, 0);
        do_read(OVF, 64'h1, 0);
        do_write(OVF, 64'h1, 0);
        do_read(OVF, 64'h0, 0);

        // Read sees pre-increment and pre-write values
        fork
            do_read(8'd4, 64'd2, 0);
            pulse(23'h8, 1);
        join
        do_read(8'd4, 64'd3, 0);
        fork
            do_read(8'd4, 64'd3, 0);
            do_write(8'd4, 64'd77, 0);
        join
        do_read(8'd4, 64'd77, 0);

        // Out-of-range accesses
        do_read(8'd200, 64'd0, 0);
        do_read(8'd25, 64'd0, 0);
        do_write(8'd200, 64'd123, 0);
        do_read(8'd4, 64'd77, 0);
        do_read(8'd0, 64'h1, 0);

        // Counting disabled
        do_write(8'd0, 64'h0, 0);
        do_read(8'd0, 64'h0, 0);
        pulse('1, 10);
        do_read(8'd4, 64'd77, 0);
        do_read(8'd2, 64'd0, 0);
        do_read(8'd1, 64'd0, 0);

        // Reset in the middle of both handshakes
        do_write(8'd0, 64'h1, 0);
        rd_exp_q.push_back(64'd77);
        exp_wr_acks++;
        @(posedge clk); #1;
        counter_read_address  = 8'd4;
        counter_write_address = 8'd2;
        counter_write_data    = 64'd999;
        counter_read_enable   = 1'b1;
        counter_write_enable  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check64("mid_rd_valid", 64'(counter_read_valid), 64'd1);
        check64("mid_wr_valid", 64'(counter_write_valid), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check64("rst_rd_valid", 64'(counter_read_valid), 64'd0);
        check64("rst_wr_valid", 64'(counter_write_valid), 64'd0);
        check64("rst_rd_data", counter_read_data, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        rd_exp_q.push_back(64'd0);
        exp_wr_acks++;
        @(negedge clk);
        check64("post_rst_rd_valid_low", 64'(counter_read_valid), 64'd0);
        @(negedge clk);
        check64("post_rst_rd_valid", 64'(counter_read_valid), 64'd1);
        check64("post_rst_wr_valid", 64'(counter_write_valid), 64'd1);
        @(posedge clk); #1;
        counter_read_enable  = 1'b0;
        counter_write_enable = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check64("post_rst_rd_drop", 64'(counter_read_valid), 64'd0);
        check64("post_rst_wr_drop", 64'(counter_write_valid), 64'd0);
        $display("reset during read addr=4 and write addr=2, reissued after reset");
        do_read(8'd2, 64'd999, 0);
        do_read(8'd4, 64'd0, 0);
        do_read(OVF, 64'd0, 0);
        do_read(8'd0, 64'd0, 0);

        repeat (3) @(negedge clk);
        check64("rd_queue_empty", 64'(rd_exp_q.size()), 64'd0);
        check64("wr_ack_count", 64'(wr_acks), 64'(exp_wr_acks));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
